// File: rtl/fpaddsub_align_pipe.sv
// FP32 add/sub pre-add alignment: unpack, order by magnitude, denormalize
// the smaller mantissa with sticky folding. Two-stage elastic pipeline.
module fpaddsub_align_pipe #(
  parameter int MW    = 26,
  parameter int EW    = 8,
  parameter int SHMAX = 26
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          InValid,
  output logic          InReady,
  input  logic [31:0]   A,
  input  logic [31:0]   B,
  input  logic          Op,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [MW-1:0] Mmax,
  output logic [MW-1:0] Mmin,
  output logic [EW-1:0] Emax,
  output logic          SignMax,
  output logic          SignMin,
  output logic          Swap,
  output logic [4:0]    Shift
);

  logic          v1_q, v2_q, ld2;
  logic [MW-1:0] mx1_q, mn1_q, mx1_d, mn1_d;
  logic [EW-1:0] e1_q, e1_d;
  logic          smx1_q, smn1_q, sw1_q;
  logic          smx1_d, smn1_d, sw1_d;
  logic [4:0]    sh1_q, sh1_d;

  logic [EW-1:0] ea, eb, eae, ebe;
  logic [EW-1:0] emx_eff, emn_eff, diff;
  logic          ha, hb, sb;
  logic [MW-1:0] ma, mb;

  logic [MW-1:0] mmax_q, mmin_q, mmin_d;
  logic [MW-1:0] mask, shifted;
  logic          sticky;
  logic [EW-1:0] emax_q;
  logic          smax_q, smin_q, swap_q;
  logic [4:0]    shift_q;

  assign ld2     = ~v2_q | OutReady;
  assign InReady = ~v1_q | ld2;

  // Stage 1: unpack and order; exponent 0 behaves as 1 for alignment
  always_comb begin
    ea      = A[30:23];
    eb      = B[30:23];
    ha      = |ea;
    hb      = |eb;
    eae     = ha ? ea : 8'd1;
    ebe     = hb ? eb : 8'd1;
    ma      = {ha, A[22:0], 2'b00};
    mb      = {hb, B[22:0], 2'b00};
    sb      = B[31] ^ Op;
    sw1_d   = A[30:0] < B[30:0];
    mx1_d   = sw1_d ? mb : ma;
    mn1_d   = sw1_d ? ma : mb;
    e1_d    = sw1_d ? eb : ea;
    smx1_d  = sw1_d ? sb : A[31];
    smn1_d  = sw1_d ? A[31] : sb;
    emx_eff = sw1_d ? ebe : eae;
    emn_eff = sw1_d ? eae : ebe;
    diff    = emx_eff - emn_eff;
    sh1_d   = (diff > 8'(SHMAX)) ? 5'(SHMAX) : diff[4:0];
  end

  // Stage 2: shift with sticky; a full-width shift leaves only the sticky
  always_comb begin
    mask    = ~({MW{1'b1}} << sh1_q);
    sticky  = |(mn1_q & mask);
    shifted = mn1_q >> sh1_q;
    mmin_d  = shifted | {{(MW-1){1'b0}}, sticky};
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      mx1_q   <= '0;
      mn1_q   <= '0;
      e1_q    <= '0;
      smx1_q  <= 1'b0;
      smn1_q  <= 1'b0;
      sw1_q   <= 1'b0;
      sh1_q   <= '0;
      mmax_q  <= '0;
      mmin_q  <= '0;
      emax_q  <= '0;
      smax_q  <= 1'b0;
      smin_q  <= 1'b0;
      swap_q  <= 1'b0;
      shift_q <= '0;
    end else begin
      if (InReady) v1_q <= InValid;
      if (InReady && InValid) begin
        mx1_q  <= mx1_d;
        mn1_q  <= mn1_d;
        e1_q   <= e1_d;
        smx1_q <= smx1_d;
        smn1_q <= smn1_d;
        sw1_q  <= sw1_d;
        sh1_q  <= sh1_d;
      end
      if (ld2) v2_q <= v1_q;
      if (ld2 && v1_q) begin
        mmax_q  <= mx1_q;
        mmin_q  <= mmin_d;
        emax_q  <= e1_q;
        smax_q  <= smx1_q;
        smin_q  <= smn1_q;
        swap_q  <= sw1_q;
        shift_q <= sh1_q;
      end
    end
  end

  assign OutValid = v2_q;
  assign Mmax     = mmax_q;
  assign Mmin     = mmin_q;
  assign Emax     = emax_q;
  assign SignMax  = smax_q;
  assign SignMin  = smin_q;
  assign Swap     = swap_q;
  assign Shift    = shift_q;

endmodule

// File: tb/tb_fpaddsub_align_pipe.sv
// Bench for fpaddsub_align_pipe: directed vectors plus randomized
// streaming against an arithmetic reference model.
module tb_fpaddsub_align_pipe;

  logic        CLK = 1'b0;
  logic        RSTn, InValid, InReady, Op, OutValid, OutReady;
  logic [31:0] A, B;
  logic [25:0] Mmax, Mmin;
  logic [7:0]  Emax;
  logic        SignMax, SignMin, Swap;
  logic [4:0]  Shift;
  logic [67:0] dut_out;

  int errors = 0;
  int checks = 0;

  fpaddsub_align_pipe dut (
    .CLK(CLK), .RSTn(RSTn),
    .InValid(InValid), .InReady(InReady),
    .A(A), .B(B), .Op(Op),
    .OutValid(OutValid), .OutReady(OutReady),
    .Mmax(Mmax), .Mmin(Mmin), .Emax(Emax),
    .SignMax(SignMax), .SignMin(SignMin),
    .Swap(Swap), .Shift(Shift)
  );

  always #5 CLK = ~CLK;

  assign dut_out = {Mmax, Mmin, Emax, SignMax, SignMin, Swap, Shift};

  // Value-level model: integer mantissas, division for the shift
  function automatic logic [67:0] ref_model(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic op);
    longint ma, mb, mx, mn, mres, p;
    int ea, eb, xa, xb, d, sh, emx;
    bit bbig, sa, sb, smx, smn;
    logic [25:0] mx26, mr26;
    logic [7:0]  e8;
    logic [4:0]  s5;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = 4 * (((ea != 0) ? 64'd8388608 : 64'd0) + longint'(a[22:0]));
    mb = 4 * (((eb != 0) ? 64'd8388608 : 64'd0) + longint'(b[22:0]));
    xa = (ea == 0) ? 1 : ea;
    xb = (eb == 0) ? 1 : eb;
    sa = a[31];
    sb = b[31] ^ op;
    bbig = (b[30:0] > a[30:0]);
    if (bbig) begin
      mx = mb; mn = ma; emx = eb; d = xb - xa; smx = sb; smn = sa;
    end else begin
      mx = ma; mn = mb; emx = ea; d = xa - xb; smx = sa; smn = sb;
    end
    sh = (d > 26) ? 26 : d;
    p = longint'(1) << sh;
    mres = mn / p;
    if ((mn % p) != 0) mres = mres | 1;
    mx26 = mx[25:0];
    mr26 = mres[25:0];
    e8 = emx[7:0];
    s5 = sh[4:0];
    return {mx26, mr26, e8, smx, smn, bbig, s5};
  endfunction

  function automatic logic [31:0] rand_operand(input logic [31:0] other);
    logic [31:0] r;
    logic [7:0]  e;
    int          m;
    r = $urandom;
    m = $urandom_range(0, 7);
    if (m == 0) r = {r[31], 31'd0};
    else if (m == 1) r = {r[31], 8'd0, r[22:0]};
    else if (m == 2 || m == 3) begin
      e = other[30:23] + 8'($urandom_range(0, 60)) - 8'd30;
      r = {r[31], e, r[22:0]};
    end else if (m == 4) r = {r[31], other[30:0]};
    return r;
  endfunction

  task automatic test_reset();
    RSTn = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    A = '0; B = '0; Op = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (OutValid !== 1'b0 || dut_out !== 68'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b out=%h want v=0 out=0",
               OutValid, dut_out);
    end
    RSTn = 1'b1;
    @(negedge CLK);
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_inready: got %b want 1", InReady);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va[6], vb[6];
    logic        vo[6];
    logic [67:0] ve[6];
    va[0] = 32'h40000000; vb[0] = 32'h3F800000; vo[0] = 1'b0;
    ve[0] = {26'h2000000, 26'h1000000, 8'h80, 1'b0, 1'b0, 1'b0, 5'd1};
    va[1] = 32'h3F800000; vb[1] = 32'hC0400000; vo[1] = 1'b0;
    ve[1] = {26'h3000000, 26'h1000000, 8'h80, 1'b1, 1'b0, 1'b1, 5'd1};
    va[2] = 32'h3F800000; vb[2] = 32'h30800000; vo[2] = 1'b0;
    ve[2] = {26'h2000000, 26'h0000001, 8'h7F, 1'b0, 1'b0, 1'b0, 5'd26};
    va[3] = 32'h00000001; vb[3] = 32'h00800000; vo[3] = 1'b0;
    ve[3] = {26'h2000000, 26'h0000004, 8'h01, 1'b0, 1'b0, 1'b1, 5'd0};
    va[4] = 32'h00000000; vb[4] = 32'h00000000; vo[4] = 1'b0;
    ve[4] = 68'd0;
    va[5] = 32'h3F800000; vb[5] = 32'h3F800000; vo[5] = 1'b1;
    ve[5] = {26'h2000000, 26'h2000000, 8'h7F, 1'b0, 1'b1, 1'b0, 5'd0};
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      A = va[i]; B = vb[i]; Op = vo[i];
      InValid = 1'b1; OutReady = 1'b1;
      @(negedge CLK);
      InValid = 1'b0;
      checks++;
      if (OutValid !== 1'b0) begin
        errors++;
        $display("FAIL latency_early vec%0d: got v=%b want 0", i, OutValid);
      end
      @(negedge CLK);
      checks++;
      if (OutValid !== 1'b1 || dut_out !== ve[i]) begin
        errors++;
        $display("FAIL directed vec%0d: got v=%b out=%h want v=1 out=%h",
                 i, OutValid, dut_out, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta[4], tb2[4];
    logic [67:0] q[$];
    logic [67:0] held, e;
    int acc, outs;
    acc = 0; outs = 0; held = '0;
    for (int i = 0; i < 4; i++) begin
      ta[i]  = $urandom;
      tb2[i] = rand_operand(ta[i]);
    end
    for (int c = 0; c < 40 && outs < 4; c++) begin
      @(negedge CLK);
      OutReady = (c >= 4);
      InValid  = (acc < 4);
      if (acc < 4) begin
        A = ta[acc]; B = tb2[acc]; Op = acc[0];
      end
      #1;
      if (c == 2) begin
        checks++;
        if (InReady !== 1'b0 || acc != 2) begin
          errors++;
          $display("FAIL b2b_stall: got ready=%b acc=%0d want ready=0 acc=2",
                   InReady, acc);
        end
      end
      if (c == 3) begin
        checks++;
        if (OutValid !== 1'b1 || dut_out !== held) begin
          errors++;
          $display("FAIL b2b_hold: got v=%b out=%h want v=1 out=%h",
                   OutValid, dut_out, held);
        end
      end
      if (c == 2) held = dut_out;
      if (OutValid && OutReady) begin
        checks++;
        e = (q.size() > 0) ? q.pop_front() : 68'hx;
        if (dut_out !== e) begin
          errors++;
          $display("FAIL b2b_data item%0d: got %h want %h", outs, dut_out, e);
        end
        outs++;
      end
      if (InValid && InReady) begin
        q.push_back(ref_model(A, B, Op));
        acc++;
      end
    end
    InValid = 1'b0;
    checks++;
    if (outs != 4 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got outs=%0d left=%0d want outs=4 left=0",
               outs, q.size());
    end
  endtask

  task automatic test_random(input int ncyc);
    logic [67:0] q[$];
    logic [67:0] e;
    int n;
    n = 0;
    for (int c = 0; c < ncyc + 50; c++) begin
      if (c >= ncyc && q.size() == 0) break;
      @(negedge CLK);
      InValid  = (c < ncyc) && ($urandom_range(0, 9) < 7);
      OutReady = (c >= ncyc) || ($urandom_range(0, 9) < 6);
      A  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      B  = rand_operand(A);
      Op = 1'($urandom_range(0, 1));
      #1;
      if (OutValid && OutReady) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: got out=%h want no output", dut_out);
        end else begin
          e = q.pop_front();
          if (dut_out !== e) begin
            errors++;
            $display("FAIL rand_data n=%0d: got %h want %h", n, dut_out, e);
          end
        end
        n++;
      end
      if (InValid && InReady) q.push_back(ref_model(A, B, Op));
    end
    InValid = 1'b0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got %0d pending want 0", q.size());
    end
  endtask

  task automatic test_midreset();
    logic [67:0] e1;
    e1 = {26'h2000000, 26'h1000000, 8'h80, 1'b0, 1'b0, 1'b0, 5'd1};
    @(negedge CLK);
    OutReady = 1'b0; InValid = 1'b1;
    A = 32'h3F800000; B = 32'h30800000; Op = 1'b0;
    @(negedge CLK);
    A = 32'hC0400000; B = 32'h3F800000;
    @(negedge CLK);
    InValid = 1'b0;
    checks++;
    if (OutValid !== 1'b1 || InReady !== 1'b0) begin
      errors++;
      $display("FAIL midrst_full: got v=%b ready=%b want v=1 ready=0",
               OutValid, InReady);
    end
    RSTn = 1'b0;
    @(negedge CLK);
    checks++;
    if (OutValid !== 1'b0 || dut_out !== 68'd0 || InReady !== 1'b1) begin
      errors++;
      $display("FAIL midrst_clear: got v=%b out=%h ready=%b want 0 0 1",
               OutValid, dut_out, InReady);
    end
    RSTn = 1'b1; OutReady = 1'b1; InValid = 1'b1;
    A = 32'h40000000; B = 32'h3F800000; Op = 1'b0;
    @(negedge CLK);
    InValid = 1'b0;
    checks++;
    if (OutValid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_stale: got v=%b want 0", OutValid);
    end
    @(negedge CLK);
    checks++;
    if (OutValid !== 1'b1 || dut_out !== e1) begin
      errors++;
      $display("FAIL midrst_after: got v=%b out=%h want v=1 out=%h",
               OutValid, dut_out, e1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random(400);
    test_midreset();
    test_random(200);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
